dmem_arbiter: RTL and testbench

Sequencing controller and two-port arbiter in front of the 64-byte data memory. It shares the memory between the CPU MEM stage (port C) and a debug/loader port (port D). It drives one word access at a time, retries on memory miss (DMemError), and produces the CPU stall. It sits between the pipeline MEM stage and DataMemoryFile.

---
 rtl/dmem_arb_pkg.sv | 26 ++
 rtl/dmem_arb_if.sv | 47 ++++
 rtl/dmem_arb_grant.sv | 45 ++++
 rtl/dmem_arbiter.sv | 159 +++++++++++++++
 tb/tb_dmem_arbiter.sv | 321 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter.
// Holds the sequencer state encoding, the port owner codes, the defaults
// for miss handling, and the address legality check.
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WAIT   = 2'd2
    } state_e;

    localparam logic        OWN_C         = 1'b0;
    localparam logic        OWN_D         = 1'b1;
    localparam logic [31:0] ERR_DATA      = 32'h0;
    localparam int          MEM_BYTES_DEF = 64;
    localparam int          MISS_WAIT_DEF = 2;
    localparam int          MAX_RETRY_DEF = 3;

    // A word access is illegal when misaligned or when its last byte falls
    // outside the memory. The sum is done in 33 bits so that addresses near
    // 2^32 cannot wrap back into range.
    function automatic logic addr_bad(input logic [31:0] addr, input int unsigned mem_bytes);
        return (addr[1:0] != 2'b00) || (({1'b0, addr} + 33'd3) >= 33'(mem_bytes));
    endfunction

endpackage

// File: rtl/dmem_arb_if.sv
// Bundle of the CPU port (c_*), the debug/loader port (d_*) and the
// DataMemoryFile side (mem_*). The arbiter uses the slave modport; the
// requesters and the memory together form the master side.
interface dmem_arb_if;
    logic        c_req;
    logic        c_we;
    logic [31:0] c_addr;
    logic [31:0] c_wdata;
    logic        c_rsp_valid;
    logic [31:0] c_rdata;
    logic        c_err;
    logic        c_stall;

    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_rsp_valid;
    logic [31:0] d_rdata;
    logic        d_err;
    logic        d_stall;

    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_write;
    logic        mem_read;
    logic [31:0] mem_rdata;
    logic        mem_miss;

    modport slave (
        input  c_req, c_we, c_addr, c_wdata,
        output c_rsp_valid, c_rdata, c_err, c_stall,
        input  d_req, d_we, d_addr, d_wdata,
        output d_rsp_valid, d_rdata, d_err, d_stall,
        output mem_addr, mem_wdata, mem_write, mem_read,
        input  mem_rdata, mem_miss
    );

    modport master (
        output c_req, c_we, c_addr, c_wdata,
        input  c_rsp_valid, c_rdata, c_err, c_stall,
        output d_req, d_we, d_addr, d_wdata,
        input  d_rsp_valid, d_rdata, d_err, d_stall,
        input  mem_addr, mem_wdata, mem_write, mem_read,
        output mem_rdata, mem_miss
    );
endinterface

// File: rtl/dmem_arb_grant.sv
// Grant selection between the CPU and debug ports.
// Build option DMEM_ARB_RR_EN: when defined, ties are broken round-robin
// using a last-owner register; otherwise the CPU port always wins a tie.
module dmem_arb_grant
    import dmem_arb_pkg::*;
(
    input  logic clk_i,
    input  logic rst_i,
    input  logic c_elig_i,
    input  logic d_elig_i,
    input  logic upd_i,        // a grant is being taken this cycle
    output logic gnt_valid_o,
    output logic gnt_owner_o
);

    assign gnt_valid_o = c_elig_i | d_elig_i;

`ifdef DMEM_ARB_RR_EN
    logic last_q, last_d;

    // Single requester wins outright; a tie goes to the port that did not own last.
    always_comb begin
        gnt_owner_o = c_elig_i ? OWN_C : OWN_D;
        if (c_elig_i && d_elig_i) gnt_owner_o = ~last_q;
    end

    // Remember the owner of every grant taken.
    always_comb begin
        last_d = last_q;
        if (upd_i) last_d = gnt_owner_o;
    end

    // Last-owner starts as D so the first tie after reset goes to C.
    always_ff @(posedge clk_i) begin
        if (rst_i) last_q <= OWN_D;
        else       last_q <= last_d;
    end
`else
    // Fixed priority needs no history.
    logic unused_ok;
    assign unused_ok   = ^{clk_i, rst_i, upd_i};
    assign gnt_owner_o = c_elig_i ? OWN_C : OWN_D;
`endif

endmodule

// File: rtl/dmem_arbiter.sv
// Sequencer and two-port arbiter in front of the 64-byte data memory.
// Runs one word access at a time, retries on memory miss and produces the
// per-port response strobes and CPU stall.
// Build option DMEM_ARB_RR_EN (in dmem_arb_grant) selects round-robin ties.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int MEM_BYTES = MEM_BYTES_DEF,
    parameter int MISS_WAIT = MISS_WAIT_DEF,
    parameter int MAX_RETRY = MAX_RETRY_DEF
) (
    input  logic       clk_i,
    input  logic       rst_i,
    dmem_arb_if.slave  bus_if
);

    localparam int RW = $clog2(MAX_RETRY + 2);
    localparam int WW = $clog2(MISS_WAIT + 1);

    state_e            state_q, state_d;
    logic              we_q, we_d;
    logic [31:0]       addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              owner_q, owner_d;
    logic [RW-1:0]     retry_q, retry_d;
    logic [WW-1:0]     wcnt_q, wcnt_d;
    logic [1:0]        rsp_q, rsp_d;
    logic [1:0]        err_q, err_d;
    logic [1:0][31:0]  rdata_q, rdata_d;
    logic [31:0]       mem_addr_q, mem_addr_d;
    logic [31:0]       mem_wdata_q, mem_wdata_d;

    logic              c_elig, d_elig, gnt_valid, gnt_owner, gnt_take;
    logic              g_we;
    logic [31:0]       g_addr, g_wdata;

    // A port that is being answered this cycle is not eligible, so a
    // requester still holding req during its strobe is not re-granted.
    assign c_elig   = bus_if.c_req & ~rsp_q[OWN_C];
    assign d_elig   = bus_if.d_req & ~rsp_q[OWN_D];
    assign gnt_take = (state_q == IDLE) & gnt_valid;

    dmem_arb_grant u_grant (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .c_elig_i    (c_elig),
        .d_elig_i    (d_elig),
        .upd_i       (gnt_take),
        .gnt_valid_o (gnt_valid),
        .gnt_owner_o (gnt_owner)
    );

    assign g_we    = (gnt_owner == OWN_D) ? bus_if.d_we    : bus_if.c_we;
    assign g_addr  = (gnt_owner == OWN_D) ? bus_if.d_addr  : bus_if.c_addr;
    assign g_wdata = (gnt_owner == OWN_D) ? bus_if.d_wdata : bus_if.c_wdata;

    // Sequencer next-state: grant/check in IDLE, one-cycle ACCESS, miss back-off in WAIT.
    always_comb begin
        state_d     = state_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        owner_d     = owner_q;
        retry_d     = retry_q;
        wcnt_d      = wcnt_q;
        rsp_d       = '0;
        err_d       = '0;
        rdata_d     = '0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;

        unique case (state_q)
            IDLE: begin
                if (gnt_valid) begin
                    we_d    = g_we;
                    addr_d  = g_addr;
                    wdata_d = g_wdata;
                    owner_d = gnt_owner;
                    retry_d = '0;
                    if (addr_bad(g_addr, MEM_BYTES)) begin
                        // Rejected without touching memory; answer next cycle.
                        rsp_d[gnt_owner] = 1'b1;
                        err_d[gnt_owner] = 1'b1;
                    end else begin
                        state_d     = ACCESS;
                        mem_addr_d  = g_addr;
                        mem_wdata_d = g_wdata;
                    end
                end
            end
            ACCESS: begin
                if (!bus_if.mem_miss) begin
                    rsp_d[owner_q]   = 1'b1;
                    rdata_d[owner_q] = we_q ? ERR_DATA : bus_if.mem_rdata;
                    state_d          = IDLE;
                end else if (retry_q < RW'(MAX_RETRY)) begin
                    retry_d = retry_q + 1'b1;
                    wcnt_d  = WW'(MISS_WAIT);
                    state_d = WAIT;
                end else begin
                    rsp_d[owner_q] = 1'b1;
                    err_d[owner_q] = 1'b1;
                    state_d        = IDLE;
                end
            end
            WAIT: begin
                if (wcnt_q == WW'(1)) state_d = ACCESS;
                else                  wcnt_d  = wcnt_q - 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and registered outputs; reset abandons any in-flight access silently.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            owner_q     <= OWN_C;
            retry_q     <= '0;
            wcnt_q      <= '0;
            rsp_q       <= '0;
            err_q       <= '0;
            rdata_q     <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            owner_q     <= owner_d;
            retry_q     <= retry_d;
            wcnt_q      <= wcnt_d;
            rsp_q       <= rsp_d;
            err_q       <= err_d;
            rdata_q     <= rdata_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    assign bus_if.c_rsp_valid = rsp_q[OWN_C];
    assign bus_if.c_err       = err_q[OWN_C];
    assign bus_if.c_rdata     = rdata_q[OWN_C];
    assign bus_if.c_stall     = bus_if.c_req & ~rsp_q[OWN_C];
    assign bus_if.d_rsp_valid = rsp_q[OWN_D];
    assign bus_if.d_err       = err_q[OWN_D];
    assign bus_if.d_rdata     = rdata_q[OWN_D];
    assign bus_if.d_stall     = bus_if.d_req & ~rsp_q[OWN_D];

    assign bus_if.mem_addr    = mem_addr_q;
    assign bus_if.mem_wdata   = mem_wdata_q;
    assign bus_if.mem_read    = (state_q == ACCESS) & ~we_q;
    assign bus_if.mem_write   = (state_q == ACCESS) & we_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: byte-array memory model with
// injectable misses, expected responses queued at issue time.
module tb_dmem_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    dmem_arb_if bus ();

    dmem_arbiter dut (
        .clk_i  (clk),
        .rst_i  (rst),
        .bus_if (bus)
    );

    typedef struct {
        logic        port;
        logic [31:0] rdata;
        logic        err;
        int          lat;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    // Memory model: combinational little-endian read, write on clock edge.
    logic [7:0] mem [64];
    int acc_cnt = 0, miss_cnt = 0, miss_base = 0, miss_budget = 0;
    logic [5:0] ma;
    assign ma            = bus.mem_addr[5:0];
    assign bus.mem_rdata = {mem[ma + 6'd3], mem[ma + 6'd2], mem[ma + 6'd1], mem[ma]};
    assign bus.mem_miss  = (bus.mem_read | bus.mem_write) && ((miss_cnt - miss_base) < miss_budget);

    always @(posedge clk) begin
        if (bus.mem_read | bus.mem_write) acc_cnt <= acc_cnt + 1;
        if ((bus.mem_read | bus.mem_write) && bus.mem_miss) miss_cnt <= miss_cnt + 1;
        if (bus.mem_write && !bus.mem_miss) begin
            mem[ma]        <= bus.mem_wdata[7:0];
            mem[ma + 6'd1] <= bus.mem_wdata[15:8];
            mem[ma + 6'd2] <= bus.mem_wdata[23:16];
            mem[ma + 6'd3] <= bus.mem_wdata[31:24];
        end
    end

    task automatic wait_rsp(input logic port, input int max, output int lat, output bit got);
        lat = 0;
        got = 1'b0;
        while (!got && lat < max) begin
            @(negedge clk);
            lat++;
            if (port ? bus.d_rsp_valid : bus.c_rsp_valid) got = 1'b1;
        end
    endtask

    // Issue one access on a port and return what came back; a timeout
    // reports latency -1 so the caller's latency comparison fails.
    task automatic do_access(input logic port, input logic we, input logic [31:0] addr,
                             input logic [31:0] wdata, input int max, output int lat,
                             output logic [31:0] rdata, output logic err, output int nacc);
        int a0;
        bit got;
        @(negedge clk);
        if (port) begin
            bus.d_req = 1'b1; bus.d_we = we; bus.d_addr = addr; bus.d_wdata = wdata;
        end else begin
            bus.c_req = 1'b1; bus.c_we = we; bus.c_addr = addr; bus.c_wdata = wdata;
        end
        a0 = acc_cnt;
        wait_rsp(port, max, lat, got);
        rdata = port ? bus.d_rdata : bus.c_rdata;
        err   = port ? bus.d_err : bus.c_err;
        nacc  = acc_cnt - a0;
        if (!got) lat = -1;
        bus.c_req = 1'b0;
        bus.d_req = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        total++;
        if ({bus.c_rsp_valid, bus.c_err, bus.c_stall, bus.d_rsp_valid, bus.d_err, bus.d_stall,
             bus.mem_read, bus.mem_write} !== 8'h0) begin
            bad++; $display("FAIL reset_flags: got %b want 0", {bus.c_rsp_valid, bus.c_err,
                bus.c_stall, bus.d_rsp_valid, bus.d_err, bus.d_stall, bus.mem_read, bus.mem_write});
        end
        total++;
        if ({bus.c_rdata, bus.d_rdata, bus.mem_addr, bus.mem_wdata} !== 128'h0) begin
            bad++; $display("FAIL reset_data: got %h %h %h %h want 0", bus.c_rdata, bus.d_rdata,
                bus.mem_addr, bus.mem_wdata);
        end
        rst = 1'b0;
    endtask

    // Loader port fills the words used later by the CPU-side tests.
    task automatic test_preload();
        int lat, na; logic [31:0] rd; logic er; exp_t e;
        logic [31:0] words [2];
        logic [31:0] addrs [2];
        words = '{32'h44332211, 32'h04030201};
        addrs = '{32'h04, 32'h3C};
        for (int i = 0; i < 2; i++) begin
            exp_q.push_back('{1'b1, 32'h0, 1'b0, 2});
            do_access(1'b1, 1'b1, addrs[i], words[i], 10, lat, rd, er, na);
            e = exp_q.pop_front();
            total++;
            if (lat !== e.lat || {er, rd} !== {e.err, e.rdata}) begin
                bad++; $display("FAIL preload_rsp%0d: got lat=%0d err=%b rdata=%h want lat=%0d err=%b rdata=%h",
                    i, lat, er, rd, e.lat, e.err, e.rdata);
            end
        end
        total++;
        if ({mem[7], mem[6], mem[5], mem[4]} !== 32'h44332211) begin
            bad++; $display("FAIL preload_bytes: got %h want 44332211", {mem[7], mem[6], mem[5], mem[4]});
        end
    endtask

    task automatic test_load_hit();
        exp_t e;
        @(negedge clk);
        bus.c_req = 1'b1; bus.c_we = 1'b0; bus.c_addr = 32'h04; bus.c_wdata = 32'h0;
        exp_q.push_back('{1'b0, 32'h44332211, 1'b0, 2});
        @(negedge clk);
        total++;
        if ({bus.mem_read, bus.mem_write, bus.c_stall, bus.c_rsp_valid} !== 4'b1010 || bus.mem_addr !== 32'h04) begin
            bad++; $display("FAIL hit_access: got rd/wr/stall/rsp=%b addr=%h want 1010 addr=4",
                {bus.mem_read, bus.mem_write, bus.c_stall, bus.c_rsp_valid}, bus.mem_addr);
        end
        @(negedge clk);
        e = exp_q.pop_front();
        total++;
        if ({bus.c_rsp_valid, bus.c_stall, bus.c_err, bus.c_rdata} !== {1'b1, 1'b0, e.err, e.rdata}) begin
            bad++; $display("FAIL hit_rsp: got rsp=%b stall=%b err=%b rdata=%h want 1 0 %b %h",
                bus.c_rsp_valid, bus.c_stall, bus.c_err, bus.c_rdata, e.err, e.rdata);
        end
        bus.c_req = 1'b0;
        @(negedge clk);
        total++;
        if ({bus.c_rsp_valid, bus.c_rdata, bus.mem_read} !== 34'h0 || bus.mem_addr !== 32'h04) begin
            bad++; $display("FAIL hit_after: got rsp=%b rdata=%h rd=%b addr=%h want 0 0 0 addr=4",
                bus.c_rsp_valid, bus.c_rdata, bus.mem_read, bus.mem_addr);
        end
    endtask

    task automatic test_store_load();
        int lat, na; logic [31:0] rd; logic er; exp_t e;
        exp_q.push_back('{1'b0, 32'h0, 1'b0, 2});
        do_access(1'b0, 1'b1, 32'h08, 32'hDEADBEEF, 10, lat, rd, er, na);
        e = exp_q.pop_front();
        total++;
        if (lat !== e.lat || {er, rd} !== {e.err, e.rdata}) begin
            bad++; $display("FAIL store_rsp: got lat=%0d err=%b rdata=%h want lat=%0d err=%b rdata=%h",
                lat, er, rd, e.lat, e.err, e.rdata);
        end
        total++;
        if ({mem[8], mem[9], mem[10], mem[11]} !== 32'hEFBEADDE) begin
            bad++; $display("FAIL store_bytes: got %h want EFBEADDE", {mem[8], mem[9], mem[10], mem[11]});
        end
        exp_q.push_back('{1'b0, 32'hDEADBEEF, 1'b0, 2});
        do_access(1'b0, 1'b0, 32'h08, 32'h0, 10, lat, rd, er, na);
        e = exp_q.pop_front();
        total++;
        if (lat !== e.lat || {er, rd} !== {e.err, e.rdata}) begin
            bad++; $display("FAIL store_reload: got lat=%0d err=%b rdata=%h want lat=%0d err=%b rdata=%h",
                lat, er, rd, e.lat, e.err, e.rdata);
        end
    endtask

    // Both ports request together. Winner answers 2 cycles after issue; the
    // loser is granted on the IDLE cycle carrying the winner's strobe and
    // answers 2 cycles later. Round 1 first makes C the last owner.
    task automatic test_tie();
        int tc, td, lat, na, obs;
        logic [31:0] rc, rdd, rd, obs_rd;
        logic ec, edd, er, obs_er, first_d;
        exp_t e;
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        for (int r = 0; r < 2; r++) begin
            if (r == 1) begin
                exp_q.push_back('{1'b0, 32'hDEADBEEF, 1'b0, 2});
                do_access(1'b0, 1'b0, 32'h08, 32'h0, 10, lat, rd, er, na);
                e = exp_q.pop_front();
                total++;
                if (lat !== e.lat || rd !== e.rdata) begin
                    bad++; $display("FAIL tie_prep: got lat=%0d rdata=%h want lat=%0d rdata=%h", lat, rd, e.lat, e.rdata);
                end
            end
`ifdef DMEM_ARB_RR_EN
            first_d = (r == 1);
`else
            first_d = 1'b0;
`endif
            @(negedge clk);
            bus.c_req = 1'b1; bus.c_we = 1'b0; bus.c_addr = 32'h08;
            bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h04;
            if (first_d) begin
                exp_q.push_back('{1'b1, 32'h44332211, 1'b0, 2});
                exp_q.push_back('{1'b0, 32'hDEADBEEF, 1'b0, 4});
            end else begin
                exp_q.push_back('{1'b0, 32'hDEADBEEF, 1'b0, 2});
                exp_q.push_back('{1'b1, 32'h44332211, 1'b0, 4});
            end
            tc = -1; td = -1; rc = '0; rdd = '0; ec = 1'b0; edd = 1'b0;
            for (int k = 1; k <= 20 && (tc < 0 || td < 0); k++) begin
                @(negedge clk);
                if (bus.c_rsp_valid && tc < 0) begin tc = k; rc = bus.c_rdata; ec = bus.c_err; bus.c_req = 1'b0; end
                if (bus.d_rsp_valid && td < 0) begin td = k; rdd = bus.d_rdata; edd = bus.d_err; bus.d_req = 1'b0; end
            end
            bus.c_req = 1'b0; bus.d_req = 1'b0;
            for (int j = 0; j < 2; j++) begin
                e      = exp_q.pop_front();
                obs    = e.port ? td : tc;
                obs_rd = e.port ? rdd : rc;
                obs_er = e.port ? edd : ec;
                total++;
                if (obs !== e.lat || {obs_er, obs_rd} !== {e.err, e.rdata}) begin
                    bad++; $display("FAIL tie%0d_port%0d: got lat=%0d err=%b rdata=%h want lat=%0d err=%b rdata=%h",
                        r, e.port, obs, obs_er, obs_rd, e.lat, e.err, e.rdata);
                end
            end
        end
    endtask

    // One miss gives ACCESS, 2 WAIT, ACCESS, strobe; a stuck miss gives
    // 1+3 accesses with WAIT pairs between, then an error strobe.
    task automatic test_miss();
        int lat, na; logic [31:0] rd; logic er; exp_t e;
        int budgets [2];
        int accs [2];
        budgets = '{1, 1000};
        accs    = '{2, 4};
        exp_q.push_back('{1'b0, 32'h44332211, 1'b0, 5});
        exp_q.push_back('{1'b0, 32'h0, 1'b1, 11});
        for (int i = 0; i < 2; i++) begin
            miss_base = miss_cnt; miss_budget = budgets[i];
            do_access(1'b0, 1'b0, 32'h04, 32'h0, 30, lat, rd, er, na);
            miss_budget = 0;
            e = exp_q.pop_front();
            total++;
            if (lat !== e.lat || na !== accs[i] || {er, rd} !== {e.err, e.rdata}) begin
                bad++; $display("FAIL miss%0d: got lat=%0d acc=%0d err=%b rdata=%h want lat=%0d acc=%0d err=%b rdata=%h",
                    i, lat, na, er, rd, e.lat, accs[i], e.err, e.rdata);
            end
        end
    endtask

    task automatic test_bad_addr();
        int lat, na; logic [31:0] rd; logic er; exp_t e;
        logic [31:0] addrs [5];
        logic        wes [5];
        addrs = '{32'h02, 32'h3D, 32'h40, 32'hFFFFFFFC, 32'h3C};
        wes   = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 4; i++) exp_q.push_back('{1'b1, 32'h0, 1'b1, 1});
        exp_q.push_back('{1'b1, 32'h04030201, 1'b0, 2});
        for (int i = 0; i < 5; i++) begin
            do_access(1'b1, wes[i], addrs[i], 32'h12345678, 10, lat, rd, er, na);
            e = exp_q.pop_front();
            total++;
            if (lat !== e.lat || na !== (e.err ? 0 : 1) || {er, rd} !== {e.err, e.rdata}) begin
                bad++; $display("FAIL addr_%h: got lat=%0d acc=%0d err=%b rdata=%h want lat=%0d acc=%0d err=%b rdata=%h",
                    addrs[i], lat, na, er, rd, e.lat, e.err ? 0 : 1, e.err, e.rdata);
            end
        end
    endtask

    task automatic test_reset_wait();
        int a0; bit seen;
        miss_base = miss_cnt; miss_budget = 1000;
        @(negedge clk);
        bus.c_req = 1'b1; bus.c_we = 1'b0; bus.c_addr = 32'h04;
        @(negedge clk);
        @(negedge clk);
        total++;
        if ({bus.mem_read, bus.mem_write, bus.c_stall} !== 3'b001) begin
            bad++; $display("FAIL rstwait_in_wait: got rd/wr/stall=%b want 001", {bus.mem_read, bus.mem_write, bus.c_stall});
        end
        rst = 1'b1; bus.c_req = 1'b0;
        @(negedge clk);
        total++;
        if ({bus.c_rsp_valid, bus.c_err, bus.c_rdata, bus.mem_read, bus.mem_write, bus.mem_addr} !== 68'h0) begin
            bad++; $display("FAIL rstwait_outputs: got rsp=%b err=%b rdata=%h rd=%b wr=%b addr=%h want all 0",
                bus.c_rsp_valid, bus.c_err, bus.c_rdata, bus.mem_read, bus.mem_write, bus.mem_addr);
        end
        rst = 1'b0;
        a0 = acc_cnt; seen = 1'b0;
        repeat (8) begin
            @(negedge clk);
            seen |= bus.c_rsp_valid | bus.d_rsp_valid;
        end
        miss_budget = 0;
        total++;
        if (seen !== 1'b0 || (acc_cnt - a0) !== 0) begin
            bad++; $display("FAIL rstwait_quiet: got rsp_seen=%b acc=%0d want 0 0", seen, acc_cnt - a0);
        end
    endtask

    initial begin
        bus.c_req = 1'b0; bus.c_we = 1'b0; bus.c_addr = '0; bus.c_wdata = '0;
        bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;
        test_reset();
        test_preload();
        test_load_hit();
        test_store_load();
        test_tie();
        test_miss();
        test_bad_addr();
        test_reset_wait();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule
